// File: rtl/multicycle_control_unit.sv
// Moore-style control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and redirects fetch to the interrupt vector when a request is pending.
module multicycle_control_unit #(
    parameter int RESET_STATE_EXIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       interruptRequest,
    output logic [1:0] aluControl,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSource,
    output logic [1:0] regWrite,
    output logic [1:0] regDst,
    output logic [1:0] memToReg,
    output logic       isInterrupted,
    output logic       isBranch,
    output logic       pcWrite,
    output logic       lorD,
    output logic       memWrite,
    output logic       IrWrite,
    output logic       illegalOp,
    output logic [3:0] stateOut
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        INTFETCH = 4'd2,
        DECODE   = 4'd3,
        MEMADR   = 4'd4,
        MEMREAD  = 4'd5,
        MEMWB    = 4'd6,
        MEMWRITE = 4'd7,
        EXECUTE  = 4'd8,
        ALUWB    = 4'd9,
        BRANCH   = 4'd10,
        ADDIEXEC = 4'd11,
        ADDIWB   = 4'd12,
        JUMP     = 4'd13,
        JAL      = 4'd14
    } state_t;

    localparam int CNT_W = (RESET_STATE_EXIT > 1) ? $clog2(RESET_STATE_EXIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_STATE_EXIT - 1);

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    state_t           state_q, state_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           fetch_sel;
    logic             funct_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign funct_ok = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) || (funct == 6'h25);

    // Interrupts are only taken where the next state would be a fetch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q | interruptRequest;
        fetch_sel = pending_q ? INTFETCH : FETCH;
        case (state_q)
            IDLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = fetch_sel;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FETCH:    state_d = DECODE;
            INTFETCH: begin
                state_d   = DECODE;
                pending_d = interruptRequest;
            end
            DECODE: begin
                case (op)
                    6'b000000:           state_d = EXECUTE;
                    6'b100011, 6'b101011: state_d = MEMADR;
                    6'b000100:           state_d = BRANCH;
                    6'b001000:           state_d = ADDIEXEC;
                    6'b000010:           state_d = JUMP;
                    6'b000011:           state_d = JAL;
                    default:             state_d = fetch_sel;
                endcase
            end
            MEMADR:   state_d = (op == 6'b100011) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            EXECUTE:  state_d = funct_ok ? ALUWB : fetch_sel;
            ADDIEXEC: state_d = ADDIWB;
            MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP, JAL: state_d = fetch_sel;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        aluControl    = ALU_ADD;
        aluSrcA       = 2'b00;
        aluSrcB       = 2'b00;
        pcSource      = 2'b00;
        regWrite      = 2'b00;
        regDst        = 2'b00;
        memToReg      = 2'b00;
        isInterrupted = 1'b0;
        isBranch      = 1'b0;
        pcWrite       = 1'b0;
        lorD          = 1'b0;
        memWrite      = 1'b0;
        IrWrite       = 1'b0;
        illegalOp     = 1'b0;
        case (state_q)
            FETCH, INTFETCH: begin
                IrWrite = 1'b1;
                pcWrite = 1'b1;
                aluSrcB = 2'b01;
                if (state_q == INTFETCH) begin
                    // Old PC goes to $31 while IR/PC are loaded from the vector.
                    isInterrupted = 1'b1;
                    regWrite      = 2'b01;
                    regDst        = 2'b10;
                    memToReg      = 2'b10;
                end
            end
            DECODE: begin
                aluSrcB = 2'b11;
                case (op)
                    6'b000000, 6'b100011, 6'b101011, 6'b000100,
                    6'b001000, 6'b000010, 6'b000011: illegalOp = 1'b0;
                    default:                        illegalOp = 1'b1;
                endcase
            end
            MEMADR, ADDIEXEC: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b10;
            end
            MEMREAD: lorD = 1'b1;
            MEMWB: begin
                regWrite = 2'b01;
                memToReg = 2'b01;
            end
            MEMWRITE: begin
                lorD     = 1'b1;
                memWrite = 1'b1;
            end
            EXECUTE: begin
                aluSrcA = 2'b01;
                case (funct)
                    6'h22:   aluControl = ALU_SUB;
                    6'h24:   aluControl = ALU_AND;
                    6'h25:   aluControl = ALU_OR;
                    default: aluControl = ALU_ADD;
                endcase
                illegalOp = ~funct_ok;
            end
            ALUWB: begin
                regWrite = 2'b01;
                regDst   = 2'b01;
            end
            BRANCH: begin
                aluSrcA    = 2'b01;
                aluControl = ALU_SUB;
                isBranch   = 1'b1;
                pcSource   = 2'b01;
            end
            ADDIWB: regWrite = 2'b01;
            JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
            end
            JAL: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
                regWrite = 2'b01;
                regDst   = 2'b10;
                memToReg = 2'b10;
            end
            default: ;
        endcase
    end

    assign stateOut = state_q;

endmodule
